// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding and helpers for clk_div_prog
package clk_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Smallest divisor that still yields a distinct high and low phase.
  localparam int MIN_DIV = 2;

  // High-phase length H = ceil(N/2). Evaluated at 32 bits, which is wider
  // than any divisor in use, so the +1 cannot wrap at N = 2^WIDTH-1.
  function automatic logic [31:0] half_high(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable glitch-free integer clock divider
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             load_ok;
  logic             wrap;

  assign load_ok = div_load && (div_val >= WIDTH'(MIN_DIV));
  assign wrap    = (state_q == ST_RUN) && (cnt_q == cur_div_q - WIDTH'(1));

  // Next-state: run/idle control, period counter, divisor reload and outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    err_d      = div_load && (div_val < WIDTH'(MIN_DIV));

    // A valid load always refreshes the pending slot; the last one wins.
    if (load_ok) begin
      pend_d     = div_val;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Nothing is being generated, so a pending divisor can land at once.
        if (pend_vld_q) begin
          cur_div_d = pend_q;
          ack_d     = 1'b1;
          if (!load_ok) pend_vld_d = 1'b0;
        end
        cnt_d = cur_div_d - WIDTH'(1);
        if (en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        if (wrap) begin
          // Period boundary: the only place the divisor may change while running.
          // A load on this very edge bypasses the pending slot.
          if (load_ok) begin
            cur_div_d  = div_val;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
          end else if (pend_vld_q) begin
            cur_div_d  = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
          end
          if (en) begin
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = cur_div_d - WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    endcase

    // Outputs are derived from the next count so they line up with it.
    clk_out_d = (state_d == ST_RUN) &&
                (32'(cnt_d) < half_high(32'(cur_div_d)));
    tick_d    = (state_d == ST_RUN) && (cnt_d == '0);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= WIDTH'(DEFAULT_DIV - 1);
      cur_div_q  <= WIDTH'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign div_ack = ack_q;
  assign div_err = err_q;
  assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_ack;
  logic       div_err;
  logic       clk_out;
  logic       tick;
  logic [7:0] cur_div;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .cur_div  (cur_div)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Checks clk_out/tick/div_ack at the current sample point against the
  // hand-written per-cycle strings, advancing one cycle per character.
  task automatic check_wave(input string tag, input string cp, input string tp, input string ap);
    for (int i = 0; i < cp.len(); i++) begin
      chk($sformatf("%s.clk_out[%0d]", tag, i), 32'(clk_out), 32'(cp[i] == "1"));
      chk($sformatf("%s.tick[%0d]", tag, i), 32'(tick), 32'(tp[i] == "1"));
      chk($sformatf("%s.div_ack[%0d]", tag, i), 32'(div_ack), 32'(ap[i] == "1"));
      @(negedge clk);
    end
  endtask

  int hi_cnt;
  int tick_cnt;

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    div_val  = 8'd0;
    div_load = 1'b0;
    #24;
    reset = 1'b0;
    en    = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst.clk_out", 32'(clk_out), 0);
    chk("rst.tick", 32'(tick), 0);
    chk("rst.div_ack", 32'(div_ack), 0);
    chk("rst.div_err", 32'(div_err), 0);
    chk("rst.cur_div", 32'(cur_div), 4);

    // Basic divide by 4, first sample is one cycle after the enabling edge
    @(negedge clk);
    check_wave("n4", "11001100", "10001000", "00000000");
    chk("n4.cur_div", 32'(cur_div), 4);

    // Odd divide: load 5 mid-period, applied at the next wrap
    div_load = 1'b1;
    div_val  = 8'd5;
    check_wave("ld5a", "1", "1", "0");
    div_load = 1'b0;
    check_wave("ld5b", "100", "000", "000");
    chk("n5.cur_div", 32'(cur_div), 5);
    check_wave("n5", "1110011100", "1000010000", "1000000000");

    // Invalid loads 1 then 0
    div_load = 1'b1;
    div_val  = 8'd1;
    check_wave("inv0", "1", "1", "0");
    chk("inv1.div_err", 32'(div_err), 1);
    div_val = 8'd0;
    check_wave("inv1", "1", "0", "0");
    chk("inv0.div_err", 32'(div_err), 1);
    div_load = 1'b0;
    check_wave("inv2", "1", "0", "0");
    chk("inv.div_err_clear", 32'(div_err), 0);
    check_wave("inv3", "0011100", "0010000", "0000000");
    chk("inv.cur_div", 32'(cur_div), 5);

    // Back-to-back loads 6 then 7: one ack, N=7 afterwards
    div_load = 1'b1;
    div_val  = 8'd6;
    check_wave("b2b0", "1", "1", "0");
    div_val = 8'd7;
    check_wave("b2b1", "1", "0", "0");
    div_load = 1'b0;
    check_wave("b2b2", "100", "000", "000");
    chk("n7.cur_div", 32'(cur_div), 7);
    check_wave("n7", "11110001111000", "10000001000000", "10000000000000");

    // Load coincident with the wrap edge (cnt=6) applies immediately
    check_wave("n7c", "111100", "100000", "000000");
    div_load = 1'b1;
    div_val  = 8'd3;
    check_wave("wrapld", "0", "0", "0");
    div_load = 1'b0;
    chk("n3.cur_div", 32'(cur_div), 3);
    check_wave("n3", "110110", "100100", "100000");

    // Back to N=4, then graceful stop with en dropped at cnt=0
    div_load = 1'b1;
    div_val  = 8'd4;
    check_wave("ld4a", "1", "1", "0");
    div_load = 1'b0;
    check_wave("ld4b", "10", "00", "00");
    en = 1'b0;
    check_wave("stop", "110000", "100000", "100000");
    chk("stop.cur_div", 32'(cur_div), 4);

    // Restart: output appears one cycle after the enabling edge
    en = 1'b1;
    check_wave("idle", "0", "0", "0");
    check_wave("restart", "1100", "1000", "0000");

    // Reset mid-run with a pending load of 9
    div_load = 1'b1;
    div_val  = 8'd9;
    check_wave("p9a", "1", "1", "0");
    div_load = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("mrst.clk_out", 32'(clk_out), 0);
    chk("mrst.tick", 32'(tick), 0);
    chk("mrst.div_ack", 32'(div_ack), 0);
    chk("mrst.div_err", 32'(div_err), 0);
    chk("mrst.cur_div", 32'(cur_div), 4);
    reset = 1'b0;
    @(negedge clk);
    check_wave("post", "1100110011001100", "1000100010001000", "0000000000000000");
    chk("post.cur_div", 32'(cur_div), 4);

    // Maximum divisor 255: H=128
    div_load = 1'b1;
    div_val  = 8'd255;
    check_wave("ld255a", "1", "1", "0");
    div_load = 1'b0;
    check_wave("ld255b", "100", "000", "000");
    chk("n255.cur_div", 32'(cur_div), 255);
    chk("n255.div_ack", 32'(div_ack), 1);
    hi_cnt   = 0;
    tick_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      if (clk_out) hi_cnt++;
      if (tick) tick_cnt++;
      if (i == 127) chk("n255.last_high", 32'(clk_out), 1);
      if (i == 128) chk("n255.first_low", 32'(clk_out), 0);
      @(negedge clk);
    end
    chk("n255.high_count", 32'(hi_cnt), 128);
    chk("n255.tick_count", 32'(tick_cnt), 1);
    chk("n255.wrap_tick", 32'(tick), 1);
    chk("n255.wrap_clk", 32'(clk_out), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable integer clock divider, the parametrised successor to the fixed clk_div_N. It generates clk_out at f_clk/N for any N from 2 to 2^WIDTH-1, including odd N, plus a one-cycle tick at each period start. Divisor changes and enable/disable take effect only on period boundaries, so clk_out never glitches. It feeds peripheral timing and generic slow-clock consumers; clk_out is a registered logic signal, not a clock-tree root.

Parameters:
WIDTH, 8, bit width of the divisor and internal counter.
DEFAULT_DIV, 4, divisor active after reset; legal range 2 to 2^WIDTH-1.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  run request; level-sensitive.
div_val  input  WIDTH  new divisor, sampled when div_load=1.
div_load  input  1  one-cycle strobe requesting a divisor change.
div_ack  output  1  one-cycle pulse when the pending divisor becomes active.
div_err  output  1  one-cycle pulse when a load is rejected (div_val<2).
clk_out  output  1  divided output, high for H=ceil(N/2) cycles of each N-cycle period.
tick  output  1  one-cycle pulse in the first cycle of each period.
cur_div  output  WIDTH  currently active divisor N.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values:
  - state=IDLE, cnt=DEFAULT_DIV-1, cur_div=DEFAULT_DIV.
  - clk_out=0, tick=0, div_ack=0, div_err=0.
  - Pending flag cleared.
  - A reset asserted mid-operation discards any pending load and forces these values at the next edge.
- FSM states and transitions:
  - IDLE: cnt held at N-1, clk_out=0. If en=1 at an edge, go to RUN with cnt<=0.
  - RUN: cnt <= (cnt==N-1) ? 0 : cnt+1. At the wrap edge (cnt==N-1), if en=0, go to IDLE instead of wrapping.
  - Dropping en mid-period therefore completes the current period before stopping (graceful stop, no truncated high phase).
- Output registers, computed from next-state cnt:
  - clk_out <= RUN_next && cnt_next < H.
  - tick <= RUN_next && cnt_next==0.
  - H=(N+1)>>1, evaluated in WIDTH+1 bits so N=2^WIDTH-1 does not overflow.
  - Latency: the first edge with en=1 in IDLE produces clk_out=1 and tick=1 in the following cycle.
- Divisor load:
  - div_load with div_val>=2: store div_val as pending and set the pending flag.
  - div_load with div_val<2: div_err=1 for one cycle after the edge; pending value and flag unchanged.
  - A load while a value is already pending overwrites it (last wins); only one div_ack is issued.
- Applying the pending divisor:
  - In RUN, it is applied at the wrap edge: cur_div<=pending and the new period uses the new N.
  - In IDLE, it is applied at the next edge: cur_div and cnt<=new N-1.
  - div_ack pulses in the cycle after application; in RUN this coincides with tick.
  - If a load and a wrap occur on the same edge, div_val bypasses the pending register and is applied at that wrap.
- Reference waveforms, en=1 from the first edge:
  - N=4: clk_out 1,1,0,0 repeating; tick 1,0,0,0.
  - N=3: clk_out 1,1,0 repeating.
  - N=2: clk_out 1,0 repeating.

Decomposition:
- Shared package clk_div_pkg holds:
  - State encoding constants ST_IDLE=0, ST_RUN=1.
  - MIN_DIV=2.
  - A function computing H=(N+1)>>1 at WIDTH+1 bits.
- Single module; no sub-module is warranted.
- The reload logic (pending register and flag) lives inline next to the counter.

Test Plan:
- Basic divide: DEFAULT_DIV=4, 40-unit clk period, reset high 24 units then en=1 -> clk_out 1,1,0,0 repeating (period 160 units), tick every 4th cycle aligned to the clk_out rise, cur_div=4.
- Odd divide: load div_val=5 while running -> div_ack coincides with the next tick, then clk_out high 3 cycles / low 2 cycles, cur_div=5.
- Invalid load: div_val=1, then 0 -> div_err pulses once each, cur_div unchanged, no div_ack, waveform undisturbed.
- Back-to-back loads: 6 then 7 within the same period -> exactly one div_ack, next period uses N=7 (high 4 / low 3); load coincident with the wrap edge applies immediately.
- Graceful stop/restart: drop en at cnt=0 with N=4 -> two more high cycles and two low cycles, then IDLE with clk_out=0. Re-raise en -> clk_out=1 and tick=1 one cycle later.
- Reset mid-run with a pending load: load 9 then reset before the wrap -> all outputs return to reset values, cur_div=DEFAULT_DIV, no div_ack ever issued for 9. Also WIDTH=8 with N=255 -> H=128, no overflow.
